// File: rtl/led_pulse_ctrl_if.sv
// LED pulse controller bus: per-channel triggers and blink counts in, LED drive and busy flags out.
interface led_pulse_ctrl_if #(
  parameter int CH_NUM = 4,
  parameter int BN_W   = 4
);
  logic [CH_NUM-1:0]      trig;
  logic [CH_NUM*BN_W-1:0] blink_num;
  logic [CH_NUM-1:0]      led;
  logic [CH_NUM-1:0]      busy;

  modport master (
    output trig,
    output blink_num,
    input  led,
    input  busy
  );

  modport slave (
    input  trig,
    input  blink_num,
    output led,
    output busy
  );
endinterface

// File: rtl/led_pulse_ctrl.sv
// Multi-channel LED blink-burst controller: trig rising edge plays blink_num ON/OFF blinks per channel.
// Optional macro LED_ACTIVE_LOW_EN inverts the led outputs for active-low LED pins.
module led_pulse_ctrl #(
  parameter int CH_NUM  = 4,
  parameter int CNT_W   = 23,
  parameter int ON_CYC  = 4_000_000,
  parameter int OFF_CYC = 1_000_000,
  parameter int BN_W    = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  led_pulse_ctrl_if.slave bus
);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_ON = 1'b0;
`else
  localparam logic LED_ON = 1'b1;
`endif
  localparam logic LED_OFF = ~LED_ON;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  logic [CH_NUM-1:0] led_q;
  logic [CH_NUM-1:0] busy_q;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    logic            trig_d0_reg;
    logic            trig_d1_reg;
    logic            pos;
    logic [BN_W-1:0] bn_sel;
    state_t          state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [BN_W-1:0] rem_reg;
    logic            led_reg;
    logic            busy_reg;

    assign pos    = trig_d0_reg & ~trig_d1_reg;
    assign bn_sel = bus.blink_num[gi*BN_W +: BN_W];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        trig_d0_reg <= 1'b0;
        trig_d1_reg <= 1'b0;
      end else begin
        trig_d0_reg <= bus.trig[gi];
        trig_d1_reg <= trig_d0_reg;
      end
    end

    // A fresh edge always takes priority over the phase-end transition.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
        rem_reg   <= '0;
        led_reg   <= LED_OFF;
        busy_reg  <= 1'b0;
      end else if (pos) begin
        rem_reg <= bn_sel;
        if (bn_sel != '0) begin
          state_reg <= ST_ON;
          cnt_reg   <= ON_LOAD;
          led_reg   <= LED_ON;
          busy_reg  <= 1'b1;
        end else begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          led_reg   <= LED_OFF;
          busy_reg  <= 1'b0;
        end
      end else begin
        case (state_reg)
          ST_ON: begin
            if (cnt_reg == '0) begin
              state_reg <= ST_OFF;
              cnt_reg   <= OFF_LOAD;
              led_reg   <= LED_OFF;
              if (rem_reg != '0) begin
                rem_reg <= rem_reg - BN_W'(1);
              end
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          ST_OFF: begin
            if (cnt_reg == '0) begin
              if (rem_reg == '0) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end else begin
                state_reg <= ST_ON;
                cnt_reg   <= ON_LOAD;
                led_reg   <= LED_ON;
              end
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            led_reg   <= LED_OFF;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end

    assign led_q[gi]  = led_reg;
    assign busy_q[gi] = busy_reg;
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;

endmodule
